task_rr_scheduler: RTL and testbench
====================================

# task_rr_scheduler

Round-robin time-slice scheduler for up to 15 tasks. Each cycle it knows which task owns the execution resource (`oGRANT`) and how many slice ticks that task has left. Its `task_id` and `task_timer` outputs drive the two low digits of the six-digit seven-segment display. The optional 24-bit context-switch counter feeds the display's `iDIG` bus.

## Interface

Parameters:
- `NUM_TASKS`, default 4: number of schedulable tasks; legal range 1..15 (id 4'hF is reserved for idle).
- `QUANTUM`, default 9: slice length in ticks; legal range 1..15.
- `TICK_DIV`, default 50_000_000: clock cycles per tick; must be ≥1. Prescaler width is `$clog2(TICK_DIV)`, minimum 1.

Ports:
- `iCLK` in 1: the only clock; all logic is on its rising edge.
- `iRST` in 1: reset, synchronous and active-high.
- `iREADY` in NUM_TASKS: per-task ready request; level-sensitive.
- `iYIELD` in 1: the current task gives up the rest of its slice; single-cycle pulse; ignored outside RUN.
- `oGRANT` out NUM_TASKS: one-hot grant; all zero unless in RUN.
- `task_id` out 4: current task index; 4'hF when idle.
- `task_timer` out 4: ticks remaining in the current slice; 0 when not in RUN.
- `oSWITCH` out 1: one-cycle pulse on the first RUN cycle of every grant, including re-grants.
- `oSWITCH_CNT` out 24: number of context switches; see Configuration.

## Operation

The scheduler has three states: IDLE, RUN and SWITCH. It keeps a pointer `last`, the last granted task.

Reset values:
- state = IDLE
- `last` = NUM_TASKS-1, so task 0 wins first
- `task_id` = 4'hF, `task_timer` = 0, `oGRANT` = 0, `oSWITCH` = 0, `oSWITCH_CNT` = 0
- prescaler = 0

Arbitration:
- Search for the first set `iREADY` bit, starting at `(last+1) mod NUM_TASKS` and wrapping.
- It is purely combinational. Its result is registered on the state transition.

IDLE:
- If any `iREADY` bit is set, move to RUN with the selected task.
- Otherwise stay in IDLE.

Entering RUN, with selected task `s`:
- `task_id` = s, `last` = s, `oGRANT` = 1<<s, `task_timer` = QUANTUM.
- Prescaler cleared; `oSWITCH` = 1 for that cycle.

RUN:
- The prescaler counts 0..TICK_DIV-1 and wraps. Each wrap is one tick, and `task_timer` decrements by 1.
- The slice ends, and the next state is SWITCH, on any of:
  - a tick while `task_timer` == 1;
  - `iYIELD` = 1;
  - `iREADY[task_id]` = 0.
- If several of these happen in the same cycle, there is exactly one transition to SWITCH and `task_timer` does not go below 0.

SWITCH (lasts exactly one cycle):
- `oGRANT` = 0, `task_timer` = 0, `task_id` keeps the outgoing id.
- Arbitrate from `last+1`:
  - found → RUN, as described in "Entering RUN";
  - none → IDLE, with `task_id` = 4'hF.
- If the outgoing task is the only ready one, it is granted again with `task_timer` reloaded and `oSWITCH` pulsing.

Other rules:
- Changes to `iREADY` bits of non-running tasks affect only the next arbitration.
- `iRST` asserted in any state forces the reset values on the next edge. A slice in progress is lost.

## Timing

- All outputs are registered.
- `iREADY` rising in IDLE at edge k gives `oGRANT`/`oSWITCH` at edge k+1.
- A full slice lasts QUANTUM×TICK_DIV cycles in RUN plus 1 cycle in SWITCH. The gap between grants is exactly 1 cycle with `oGRANT` = 0.
- `iYIELD` sampled at edge k gives SWITCH at k+1 and the new grant at k+2.
- `task_timer` changes only on the tick cycle, or on state entry/exit.

## Configuration

The feature is controlled by the macro `SCHED_SWITCH_COUNT_EN`.

- Defined: `oSWITCH_CNT` increments by 1 on every cycle where `oSWITCH` = 1, and wraps from 24'hFFFFFF to 0. It is cleared by `iRST`.
- Undefined: no counter register is built, and `oSWITCH_CNT` is tied to 24'h000000. The port stays present.

## Test plan

All scenarios use NUM_TASKS=4, QUANTUM=3, TICK_DIV=4.

- Reset: hold `iRST` for 2 cycles with `iREADY` = 4'b1111 → `task_id` = F, `task_timer` = 0, `oGRANT` = 0, `oSWITCH` = 0 throughout; `oGRANT` = 0001 on the first edge after release.
- Rotation: `iREADY` = 4'b0101.
  - Task 0 is granted with `task_timer` = 3, counting down 3,2,1 every 4 cycles.
  - After 12 RUN cycles there is 1 SWITCH cycle, then task 2, then task 0 again.
  - `oSWITCH` pulses 13 cycles apart.
- Yield: `iREADY` = 4'b0011; pulse `iYIELD` in the 2nd cycle of task 0's slice → SWITCH on the next edge, task 1 granted one edge later with `task_timer` = 3.
- Sole task: `iREADY` = 4'b0010 → task 1 re-granted every 13 cycles, `task_timer` reloaded to 3, `task_id` stays 1.
- Drop out: clear `iREADY` entirely mid-slice → SWITCH next edge, then IDLE with `task_id` = F and `oGRANT` = 0.
- Counter: after 3 grants from reset, `oSWITCH_CNT` = 3 with `SCHED_SWITCH_COUNT_EN` defined, and 0 without it; force the counter to 24'hFFFFFF and run one switch → 0.

Source files
------------

// File: rtl/task_rr_scheduler.sv
// Round-robin time-slice scheduler: grants one of NUM_TASKS ready tasks for QUANTUM ticks of TICK_DIV cycles.
// Latency: ready-to-grant 1 cycle from IDLE; 1 idle SWITCH cycle between consecutive grants.
// Backpressure: none; a task holds its grant only while iREADY stays high and it does not yield.
// Optional context-switch counter on oSWITCH_CNT is built when SCHED_SWITCH_COUNT_EN is defined.
module task_rr_scheduler #(
  parameter int NUM_TASKS = 4,
  parameter int QUANTUM   = 9,
  parameter int TICK_DIV  = 50_000_000
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic [NUM_TASKS-1:0] iREADY,
  input  logic                 iYIELD,
  output logic [NUM_TASKS-1:0] oGRANT,
  output logic [3:0]           task_id,
  output logic [3:0]           task_timer,
  output logic                 oSWITCH,
  output logic [23:0]          oSWITCH_CNT
);

  localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST  = PW'(TICK_DIV - 1);
  localparam logic [3:0]    Q_LOAD   = 4'(QUANTUM);
  localparam logic [3:0]    LAST_RST = 4'(NUM_TASKS - 1);
  localparam logic [3:0]    IDLE_ID  = 4'hF;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SWITCH} state_t;

  state_t               state;
  logic [3:0]           last;
  logic [PW-1:0]        prescaler;

  logic                 arb_found;
  logic [3:0]           arb_sel;
  logic [NUM_TASKS-1:0] arb_onehot;
  logic                 tick;
  logic                 slice_end;

  // Round-robin search: first ready task starting just after the last grant, wrapping.
  always_comb begin
    arb_found  = 1'b0;
    arb_sel    = IDLE_ID;
    arb_onehot = '0;
    for (int i = 0; i < NUM_TASKS; i++) begin
      for (int j = 0; j < NUM_TASKS; j++) begin
        if (!arb_found && iREADY[j] && (j == ((int'(last) + 1 + i) % NUM_TASKS))) begin
          arb_found     = 1'b1;
          arb_sel       = 4'(j);
          arb_onehot[j] = 1'b1;
        end
      end
    end
  end

  // A tick is the prescaler wrap; the slice ends on the last tick, a yield, or the owner dropping ready.
  always_comb begin
    tick      = (prescaler == PS_LAST);
    slice_end = (tick && (task_timer == 4'd1)) || iYIELD || ~|(oGRANT & iREADY);
  end

  // Scheduler state machine; every output is registered here.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state      <= ST_IDLE;
      last       <= LAST_RST;
      task_id    <= IDLE_ID;
      task_timer <= 4'd0;
      oGRANT     <= '0;
      oSWITCH    <= 1'b0;
      prescaler  <= '0;
    end else begin
      oSWITCH <= 1'b0;
      case (state)
        ST_IDLE, ST_SWITCH: begin
          if (arb_found) begin
            state      <= ST_RUN;
            task_id    <= arb_sel;
            last       <= arb_sel;
            oGRANT     <= arb_onehot;
            task_timer <= Q_LOAD;
            prescaler  <= '0;
            oSWITCH    <= 1'b1;
          end else begin
            state   <= ST_IDLE;
            task_id <= IDLE_ID;
          end
        end
        ST_RUN: begin
          if (slice_end) begin
            // Outgoing id stays visible for the single SWITCH cycle.
            state      <= ST_SWITCH;
            oGRANT     <= '0;
            task_timer <= 4'd0;
          end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
              task_timer <= task_timer - 4'd1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SCHED_SWITCH_COUNT_EN
  logic [23:0] switch_cnt;

  // Count every grant pulse; wraps naturally at 24 bits.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      switch_cnt <= 24'd0;
    end else if (oSWITCH) begin
      switch_cnt <= switch_cnt + 24'd1;
    end
  end

  assign oSWITCH_CNT = switch_cnt;
`else
  assign oSWITCH_CNT = 24'h000000;
`endif

endmodule

// File: tb/tb_task_rr_scheduler.sv
// Self-checking bench for task_rr_scheduler with NUM_TASKS=4, QUANTUM=3, TICK_DIV=4.
// Grant events are queued as stimulus is applied and matched against oSWITCH pulses.
module tb_task_rr_scheduler;

  localparam int N     = 4;
  localparam int Q     = 3;
  localparam int TD    = 4;
  localparam int SLICE = Q * TD + 1;
`ifdef SCHED_SWITCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic         iCLK   = 1'b0;
  logic         iRST   = 1'b1;
  logic [N-1:0] iREADY = 4'b1111;
  logic         iYIELD = 1'b0;
  logic [N-1:0] oGRANT;
  logic [3:0]   task_id;
  logic [3:0]   task_timer;
  logic         oSWITCH;
  logic [23:0]  oSWITCH_CNT;

  task_rr_scheduler #(.NUM_TASKS(N), .QUANTUM(Q), .TICK_DIV(TD)) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iREADY      (iREADY),
    .iYIELD      (iYIELD),
    .oGRANT      (oGRANT),
    .task_id     (task_id),
    .task_timer  (task_timer),
    .oSWITCH     (oSWITCH),
    .oSWITCH_CNT (oSWITCH_CNT)
  );

  always #5 iCLK = ~iCLK;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] grant;
    logic [3:0] id;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic expect_grant(input int t, input int at);
    exp_t e;
    e.grant = 4'(1 << t);
    e.id    = 4'(t);
    e.at    = at;
    sb.push_back(e);
  endtask

  task automatic go_to(input int c);
    while (cyc < c) @(negedge iCLK);
  endtask

  // Reset for two edges, then release with the given ready pattern; k = cycle of release.
  task automatic do_reset(input logic [N-1:0] ready, output int k);
    @(negedge iCLK);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    iRST   = 1'b1;
    iYIELD = 1'b0;
    @(negedge iCLK);
    chk("rst_grant", 32'(oGRANT), 32'd0);
    chk("rst_id", 32'(task_id), 32'hF);
    chk("rst_timer", 32'(task_timer), 32'd0);
    @(negedge iCLK);
    iRST   = 1'b0;
    iREADY = ready;
    k      = cyc;
  endtask

  // Every grant pulse must match the next queued expectation, including its cycle.
  always @(negedge iCLK) begin
    if (oSWITCH === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_switch", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        chk("sw_grant", 32'(oGRANT), 32'(mon_e.grant));
        chk("sw_id", 32'(task_id), 32'(mon_e.id));
        chk("sw_timer", 32'(task_timer), 32'(Q));
        chk("sw_cycle", 32'(cyc), 32'(mon_e.at));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: no finish by cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    int g;

    // Reset held two cycles with all tasks ready.
    for (int i = 0; i < 2; i++) begin
      @(negedge iCLK);
      chk("rst0_id", 32'(task_id), 32'hF);
      chk("rst0_timer", 32'(task_timer), 32'd0);
      chk("rst0_grant", 32'(oGRANT), 32'd0);
      chk("rst0_switch", 32'(oSWITCH), 32'd0);
      chk("rst0_cnt", 32'(oSWITCH_CNT), 32'd0);
    end
    iRST = 1'b0;
    expect_grant(0, cyc + 1);
    go_to(cyc + 2);

    // Rotation between tasks 0 and 2 (reset lands mid-slice of the previous grant).
    do_reset(4'b0101, k);
    g = k + 1;
    expect_grant(0, g);
    expect_grant(2, g + SLICE);
    expect_grant(0, g + 2 * SLICE);
    go_to(g + 3);
    chk("rot_timer_3", 32'(task_timer), 32'd3);
    go_to(g + 4);
    chk("rot_timer_2", 32'(task_timer), 32'd2);
    go_to(g + 8);
    chk("rot_timer_1", 32'(task_timer), 32'd1);
    go_to(g + 11);
    chk("rot_last_run_grant", 32'(oGRANT), 32'b0001);
    go_to(g + 12);
    chk("rot_sw_grant", 32'(oGRANT), 32'd0);
    chk("rot_sw_timer", 32'(task_timer), 32'd0);
    chk("rot_sw_id", 32'(task_id), 32'd0);
    go_to(g + 2 * SLICE + 1);

    // Yield in the second cycle of task 0's slice.
    do_reset(4'b0011, k);
    g = k + 1;
    expect_grant(0, g);
    expect_grant(1, g + 3);
    go_to(g + 1);
    iYIELD = 1'b1;
    chk("yld_timer", 32'(task_timer), 32'd3);
    go_to(g + 2);
    iYIELD = 1'b0;
    chk("yld_sw_grant", 32'(oGRANT), 32'd0);
    chk("yld_sw_timer", 32'(task_timer), 32'd0);
    go_to(g + 4);
    chk("yld_new_id", 32'(task_id), 32'd1);

    // Sole ready task is re-granted each slice.
    do_reset(4'b0010, k);
    g = k + 1;
    expect_grant(1, g);
    expect_grant(1, g + SLICE);
    expect_grant(1, g + 2 * SLICE);
    go_to(g + 12);
    chk("sole_sw_grant", 32'(oGRANT), 32'd0);
    chk("sole_sw_id", 32'(task_id), 32'd1);
    go_to(g + 2 * SLICE + 1);

    // All ready bits drop mid-slice, then a new request from IDLE.
    do_reset(4'b0001, k);
    g = k + 1;
    expect_grant(0, g);
    go_to(g + 5);
    chk("drop_timer", 32'(task_timer), 32'd2);
    iREADY = 4'b0000;
    go_to(g + 6);
    chk("drop_sw_grant", 32'(oGRANT), 32'd0);
    chk("drop_sw_id", 32'(task_id), 32'd0);
    go_to(g + 7);
    chk("drop_idle_id", 32'(task_id), 32'hF);
    chk("drop_idle_timer", 32'(task_timer), 32'd0);
    go_to(g + 9);
    chk("drop_idle_grant", 32'(oGRANT), 32'd0);
    iREADY = 4'b0100;
    expect_grant(2, g + 10);
    go_to(g + 11);

    // Context switch counter.
    do_reset(4'b0011, k);
    g = k + 1;
    expect_grant(0, g);
    expect_grant(1, g + SLICE);
    expect_grant(0, g + 2 * SLICE);
    expect_grant(1, g + 3 * SLICE);
    go_to(g + 2 * SLICE);
    chk("cnt_2", 32'(oSWITCH_CNT), CNT_EN ? 32'd2 : 32'd0);
    go_to(g + 2 * SLICE + 1);
    chk("cnt_3", 32'(oSWITCH_CNT), CNT_EN ? 32'd3 : 32'd0);
`ifdef SCHED_SWITCH_COUNT_EN
    go_to(g + 2 * SLICE + 4);
    force dut.switch_cnt = 24'hFFFFFF;
    go_to(g + 2 * SLICE + 5);
    release dut.switch_cnt;
`endif
    go_to(g + 3 * SLICE + 1);
    chk("cnt_wrap", 32'(oSWITCH_CNT), 32'd0);

    @(negedge iCLK);
    chk("sb_final", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
